// File: rtl/mac9_bist_checker.sv
// mac9_bist_checker: self-test engine that drives LFSR stimulus to two mac_9 instances and compares their responses
// Ports:
//   clk, rst_n (async, active-low)   start: one-cycle run request (ignored while busy)
//   stim_a/b/c: registered stimulus    resp_fpga/resp_ref: responses of the two instances
//   busy, done, pass, err_count, first_err_idx, signature: run status and results
// Optional MISR on signature when MAC9_BIST_MISR_EN is defined; otherwise signature reads zero.
module mac9_bist_checker #(
   parameter int          WIDTH       = 9,
   parameter int          NUM_VECTORS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [26:0] LFSR_SEED   = 27'h5A5A5A5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] stim_a,
   output logic [WIDTH-1:0] stim_b,
   output logic [WIDTH-1:0] stim_c,
   input  logic [WIDTH-1:0] resp_fpga,
   input  logic [WIDTH-1:0] resp_ref,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [15:0]      first_err_idx,
   output logic [15:0]      signature
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t                   state_q, state_d;
   logic [26:0]              lfsr_q, lfsr_d;
   logic [WIDTH-1:0]         a_q, a_d, b_q, b_d, c_q, c_d;
   logic [15:0]              issue_q, issue_d, err_q, err_d, first_q, first_d;
   logic [LATENCY-1:0]       vld_q, vld_d;
   logic [LATENCY-1:0][15:0] pidx_q, pidx_d;
   logic                     restart, issue, cmp, mis;
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      issue_d = issue_q;
      err_d   = err_q;
      first_d = first_q;
      restart = (state_q == IDLE || state_q == DONE) && start;
      issue   = state_q == RUN;
      // Valid/index pipe: output stage LATENCY-1 is compared against the responses this cycle
      vld_d     = (vld_q << 1) | LATENCY'(issue);
      pidx_d[0] = issue_q;
      for (int i = 1; i < LATENCY; i++) pidx_d[i] = pidx_q[i-1];
      cmp = vld_q[LATENCY-1];
      mis = cmp && (resp_fpga != resp_ref);
      if (mis && err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (mis && first_q == 16'hFFFF) first_d = pidx_q[LATENCY-1];
      if (issue) begin
         a_d     = lfsr_q[8:0];
         b_d     = lfsr_q[17:9];
         c_d     = lfsr_q[26:18];
         lfsr_d  = {lfsr_q[25:0], lfsr_q[26] ^ lfsr_q[4] ^ lfsr_q[1] ^ lfsr_q[0]};
         issue_d = issue_q + 16'd1;
         if (issue_q == 16'(NUM_VECTORS - 1)) state_d = DRAIN;
      end
      // Leave DRAIN on the edge that consumes the last valid entry, so the final compare lands with the transition
      if (state_q == DRAIN && vld_d == '0) state_d = DONE;
      if (restart) begin
         state_d = RUN;
         lfsr_d  = LFSR_SEED;
         issue_d = '0;
         err_d   = '0;
         first_d = 16'hFFFF;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lfsr_q  <= LFSR_SEED;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         issue_q <= '0;
         err_q   <= '0;
         first_q <= 16'hFFFF;
         vld_q   <= '0;
         pidx_q  <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         issue_q <= issue_d;
         err_q   <= err_d;
         first_q <= first_d;
         vld_q   <= vld_d;
         pidx_q  <= pidx_d;
      end
   end
`ifdef MAC9_BIST_MISR_EN
   logic [15:0] misr_q, misr_d;
   always_comb
      misr_d = restart ? '0
             : cmp ? ({misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h100B : 16'h0000) ^ 16'(resp_fpga))
             : misr_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misr_q <= '0;
      else misr_q <= misr_d;
   end
   assign signature = misr_q;
`else
   assign signature = 16'h0000;
`endif
   assign stim_a        = a_q;
   assign stim_b        = b_q;
   assign stim_c        = c_q;
   assign busy          = state_q == RUN || state_q == DRAIN;
   assign done          = state_q == DONE;
   assign pass          = done && err_q == 16'h0000;
   assign err_count     = err_q;
   assign first_err_idx = first_q;
endmodule
